// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - hazard detection, forwarding select and mult/div sequencing for the 5-stage MIPS pipeline
// Keeps a shadow pipeline of dst/Tnew tags for E, M, W and derives stalls and forward selects.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [1:0] D_Tuse_rs,
  input  logic [1:0] D_Tuse_rt,
  input  logic [4:0] D_dst,
  input  logic [1:0] D_Tnew,
  input  logic       D_md_start,
  input  logic       D_md_div,
  input  logic       D_md_use,
  output logic [2:0] Forward_RS_D_src,
  output logic [2:0] Forward_RT_D_src,
  output logic [1:0] Forward_RS_E_src,
  output logic [1:0] Forward_RT_E_src,
  output logic       Forward_RT_M_src,
  output logic       PauseF,
  output logic       PauseD,
  output logic       ClearE,
  output logic       md_busy
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [4:0]       E_dst, E_rs, E_rt, M_dst, M_rt, W_dst;
  logic [1:0]       E_Tnew, M_Tnew;
  logic             E_md_start, E_md_div;
  logic [CNT_W-1:0] md_cnt;

  logic stall_rs, stall_rt, stall_md, stall;

  // A consumer must wait while a producer in E or M still needs more cycles than the consumer can spare.
  function automatic logic reg_hazard(
    input logic [4:0] r,
    input logic [1:0] tuse,
    input logic [4:0] e_d,
    input logic [1:0] e_t,
    input logic [4:0] m_d,
    input logic [1:0] m_t
  );
    return (tuse != 2'd3) && (r != 5'd0) &&
           ((e_d == r && e_t > tuse) || (m_d == r && m_t > tuse));
  endfunction

  function automatic logic [2:0] fwd_d(
    input logic [4:0] r,
    input logic [4:0] e_d,
    input logic [1:0] e_t,
    input logic [4:0] m_d,
    input logic [1:0] m_t,
    input logic [4:0] w_d
  );
    if (r == 5'd0)                     return 3'd0;
    else if (e_d == r && e_t == 2'd0)  return 3'd1;
    else if (m_d == r && m_t == 2'd0)  return 3'd2;
    else if (w_d == r)                 return 3'd3;
    else                               return 3'd0;
  endfunction

  function automatic logic [1:0] fwd_e(
    input logic [4:0] r,
    input logic [4:0] m_d,
    input logic [1:0] m_t,
    input logic [4:0] w_d
  );
    if (r != 5'd0 && m_d == r && m_t == 2'd0) return 2'd1;
    else if (r != 5'd0 && w_d == r)           return 2'd2;
    else                                      return 2'd0;
  endfunction

  always_comb begin
    md_busy  = (md_cnt != '0);
    stall_rs = reg_hazard(D_rs, D_Tuse_rs, E_dst, E_Tnew, M_dst, M_Tnew);
    stall_rt = reg_hazard(D_rt, D_Tuse_rt, E_dst, E_Tnew, M_dst, M_Tnew);
    // HI/LO readers also wait for the cycle the mult/div sits in E, before md_cnt is loaded.
    stall_md = D_md_use && (md_busy || E_md_start);
    stall    = stall_rs | stall_rt | stall_md;
    PauseF   = stall;
    PauseD   = stall;
    ClearE   = stall;
    Forward_RS_D_src = fwd_d(D_rs, E_dst, E_Tnew, M_dst, M_Tnew, W_dst);
    Forward_RT_D_src = fwd_d(D_rt, E_dst, E_Tnew, M_dst, M_Tnew, W_dst);
    Forward_RS_E_src = fwd_e(E_rs, M_dst, M_Tnew, W_dst);
    Forward_RT_E_src = fwd_e(E_rt, M_dst, M_Tnew, W_dst);
    Forward_RT_M_src = (M_rt != 5'd0) && (W_dst == M_rt);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      E_dst      <= '0;
      E_Tnew     <= '0;
      E_rs       <= '0;
      E_rt       <= '0;
      E_md_start <= 1'b0;
      E_md_div   <= 1'b0;
      M_dst      <= '0;
      M_Tnew     <= '0;
      M_rt       <= '0;
      W_dst      <= '0;
      md_cnt     <= '0;
    end else begin
      if (stall) begin
        E_dst      <= '0;
        E_Tnew     <= '0;
        E_rs       <= '0;
        E_rt       <= '0;
        E_md_start <= 1'b0;
        E_md_div   <= 1'b0;
      end else begin
        E_dst      <= D_dst;
        E_Tnew     <= D_Tnew;
        E_rs       <= D_rs;
        E_rt       <= D_rt;
        E_md_start <= D_md_start;
        E_md_div   <= D_md_div;
      end
      M_dst  <= E_dst;
      M_Tnew <= (E_Tnew == 2'd0) ? 2'd0 : E_Tnew - 2'd1;
      M_rt   <= E_rt;
      W_dst  <= M_dst;
      if (E_md_start)
        md_cnt <= E_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      else if (md_cnt != '0)
        md_cnt <= md_cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed vector bench for hazard_ctrl
module tb_hazard_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [4:0] D_rs, D_rt, D_dst;
  logic [1:0] D_Tuse_rs, D_Tuse_rt, D_Tnew;
  logic       D_md_start, D_md_div, D_md_use;
  logic [2:0] Forward_RS_D_src, Forward_RT_D_src;
  logic [1:0] Forward_RS_E_src, Forward_RT_E_src;
  logic       Forward_RT_M_src, PauseF, PauseD, ClearE, md_busy;

  int errors = 0;
  int checks = 0;

  hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk(Clk), .Reset(Reset),
    .D_rs(D_rs), .D_rt(D_rt), .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
    .D_dst(D_dst), .D_Tnew(D_Tnew),
    .D_md_start(D_md_start), .D_md_div(D_md_div), .D_md_use(D_md_use),
    .Forward_RS_D_src(Forward_RS_D_src), .Forward_RT_D_src(Forward_RT_D_src),
    .Forward_RS_E_src(Forward_RS_E_src), .Forward_RT_E_src(Forward_RT_E_src),
    .Forward_RT_M_src(Forward_RT_M_src),
    .PauseF(PauseF), .PauseD(PauseD), .ClearE(ClearE), .md_busy(md_busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [4:0] rs, rt;
    logic [1:0] tuse_rs, tuse_rt;
    logic [4:0] dst;
    logic [1:0] tnew;
    logic       md_start, md_div, md_use;
    logic       stall;
    logic [2:0] rsd, rtd;
    logic [1:0] rse, rte;
    logic       rtm;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(
    input int rs, input int rt, input int tu_rs, input int tu_rt, input int dst, input int tnew,
    input int ms, input int md, input int mu,
    input int st, input int rsd, input int rtd, input int rse, input int rte, input int rtm
  );
    vec_t v;
    v.rs = 5'(rs); v.rt = 5'(rt); v.tuse_rs = 2'(tu_rs); v.tuse_rt = 2'(tu_rt);
    v.dst = 5'(dst); v.tnew = 2'(tnew);
    v.md_start = 1'(ms); v.md_div = 1'(md); v.md_use = 1'(mu);
    v.stall = 1'(st); v.rsd = 3'(rsd); v.rtd = 3'(rtd);
    v.rse = 2'(rse); v.rte = 2'(rte); v.rtm = 1'(rtm);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    D_rs = v.rs; D_rt = v.rt; D_Tuse_rs = v.tuse_rs; D_Tuse_rt = v.tuse_rt;
    D_dst = v.dst; D_Tnew = v.tnew;
    D_md_start = v.md_start; D_md_div = v.md_div; D_md_use = v.md_use;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  // Multiply/divide window: stalls for the E cycle plus n busy cycles.
  task automatic md_window(input string name, input logic is_div, input int n);
    int cyc;
    int busy;
    cyc = 0;
    busy = 0;
    drive(mk(0, 0, 3, 3, 0, 0, 1, int'(is_div), 1, 0, 0, 0, 0, 0, 0));
    @(negedge Clk);
    chk({name, "_start_stall"}, int'(PauseF), 0);
    chk({name, "_start_busy"}, int'(md_busy), 0);
    next_cycle();
    drive(mk(0, 0, 3, 3, 2, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    @(negedge Clk);
    while (PauseF && cyc < 40) begin
      cyc++;
      if (md_busy) busy++;
      next_cycle();
      @(negedge Clk);
    end
    chk({name, "_stall_cycles"}, cyc, n + 1);
    chk({name, "_busy_cycles"}, busy, n);
    chk({name, "_release_busy"}, int'(md_busy), 0);
    next_cycle();
    drive(mk(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    vec_t nop;
    nop = mk(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    //            rs  rt tu tu dst tn ms md mu | st rsd rtd rse rte rtm
    vecs[0]  = mk( 0,  0, 3, 3,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(29,  8, 1, 3,  8, 2, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    vecs[2]  = mk( 8,  0, 0, 0,  0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    vecs[3]  = mk( 8,  0, 0, 0,  0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    vecs[4]  = mk( 8,  0, 0, 0,  0, 0, 0, 0, 0,  0, 3, 0, 0, 0, 0);
    vecs[5]  = mk(10, 11, 1, 1,  9, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    vecs[6]  = mk( 9,  9, 1, 1, 12, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    vecs[7]  = mk( 0,  0, 3, 3,  0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 0);
    vecs[8]  = mk( 0,  0, 3, 3,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
    vecs[9]  = mk( 0,  0, 3, 3, 31, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    vecs[10] = mk(31,  0, 0, 3,  0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0);
    vecs[11] = mk( 0,  0, 3, 3,  0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0);
    vecs[12] = mk(31, 31, 0, 0,  0, 0, 0, 0, 0,  0, 3, 3, 0, 0, 0);
    vecs[13] = mk( 0,  0, 3, 3,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    vecs[14] = mk(29,  0, 1, 3,  0, 2, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    vecs[15] = mk( 0,  0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    vecs[16] = mk( 0,  0, 3, 3,  5, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    vecs[17] = mk( 0,  0, 3, 3,  5, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    vecs[18] = mk( 5,  5, 0, 3,  0, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0);
    vecs[19] = mk( 0,  0, 3, 3,  0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 0);
    vecs[20] = mk( 0,  0, 3, 3,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);

    Reset = 1'b1;
    drive(mk(8, 8, 0, 0, 8, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge Clk);
    #1;
    chk("reset_ctl", int'({PauseF, PauseD, ClearE}), 0);
    chk("reset_busy", int'(md_busy), 0);
    chk("reset_fwd", int'({Forward_RS_D_src, Forward_RT_D_src, Forward_RS_E_src,
                           Forward_RT_E_src, Forward_RT_M_src}), 0);
    drive(nop);
    Reset = 1'b0;

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i]);
      @(negedge Clk);
      chk($sformatf("row%0d_ctl", i), int'({PauseF, PauseD, ClearE}), int'({3{vecs[i].stall}}));
      chk($sformatf("row%0d_rs_d", i), int'(Forward_RS_D_src), int'(vecs[i].rsd));
      chk($sformatf("row%0d_rt_d", i), int'(Forward_RT_D_src), int'(vecs[i].rtd));
      chk($sformatf("row%0d_rs_e", i), int'(Forward_RS_E_src), int'(vecs[i].rse));
      chk($sformatf("row%0d_rt_e", i), int'(Forward_RT_E_src), int'(vecs[i].rte));
      chk($sformatf("row%0d_rt_m", i), int'(Forward_RT_M_src), int'(vecs[i].rtm));
      next_cycle();
    end

    md_window("mult", 1'b0, 5);
    md_window("div", 1'b1, 10);

    // Reset in the middle of a divide (md_cnt=7) and a load-use stall.
    drive(mk(0, 0, 3, 3, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0));
    next_cycle();
    drive(nop);
    repeat (3) next_cycle();
    drive(mk(29, 8, 1, 3, 8, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    next_cycle();
    drive(mk(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge Clk);
    chk("pre_reset_stall", int'(PauseF), 1);
    chk("pre_reset_busy", int'(md_busy), 1);
    #2;
    Reset = 1'b1;
    #1;
    chk("async_reset_ctl", int'({PauseF, PauseD, ClearE}), 0);
    chk("async_reset_busy", int'(md_busy), 0);
    chk("async_reset_fwd", int'({Forward_RS_D_src, Forward_RT_D_src, Forward_RS_E_src,
                                 Forward_RT_E_src, Forward_RT_M_src}), 0);
    next_cycle();
    Reset = 1'b0;
    @(negedge Clk);
    chk("post_reset_stall", int'(PauseF), 0);
    chk("post_reset_busy", int'(md_busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
